seg7_counter_periph: RTL

Memory-mapped openMSP430 peripheral that owns the four-digit value shown on the board's seven-segment display. It sits directly upstream of the seven-segment scan driver and feeds its four nibble inputs. The value is either written by software or advanced by an internal hex/BCD up/down counter paced by a programmable prescaler. The block raises a sticky overflow flag and an optional interrupt on wrap.

---
 rtl/seg7_counter_periph.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_counter_periph.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_counter_periph                                           |
// | Purpose  : openMSP430 peripheral holding the 4-digit 7-segment value,    |
// |            with a prescaled hex/BCD up/down counter and overflow irq.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg7_counter_periph #(
  parameter logic [14:0] BASE_ADDR = 15'h0090,
  parameter int unsigned PREDIV_W  = 10
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [3:0]  s0_src,
  output logic [3:0]  s1_src,
  output logic [3:0]  s2_src,
  output logic [3:0]  s3_src,
  output logic        irq
);

  localparam logic [1:0] c_idx_disp  = 2'd0;
  localparam logic [1:0] c_idx_ctrl  = 2'd1;
  localparam logic [1:0] c_idx_presc = 2'd2;
  localparam logic [1:0] c_idx_stat  = 2'd3;

  // CNT_EN, DECIMAL, DOWN and IE are the only implemented CTRL bits
  localparam logic [5:0] c_ctrl_mask = 6'b100111;

  localparam logic [PREDIV_W-1:0] c_prediv_one = PREDIV_W'(1);

  logic [15:0]         disp_q,   disp_d;
  logic [5:0]          ctrl_q,   ctrl_d;
  logic [15:0]         presc_q,  presc_d;
  logic                ovf_q,    ovf_d;
  logic                irq_q,    irq_d;
  logic [PREDIV_W-1:0] prediv_q, prediv_d;
  logic [15:0]         pcnt_q,   pcnt_d;

  logic        w_sel;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_idx;
  logic        w_wr_disp;
  logic        w_wr_ctrl;
  logic        w_wr_presc;
  logic        w_wr_stat;
  logic        w_prediv_full;
  logic        w_tick;
  logic [15:0] w_step_val;
  logic        w_step_ovf;

  // Returns {carry_out, value}; carry/borrow ripples from the low nibble up
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic down);
    logic [15:0] r;
    logic        c;
    logic [3:0]  n;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = v[4*i +: 4];
      if (c) begin
        if (down) begin
          if (n == 4'd0) begin
            n = 4'd9;
          end else begin
            n = (n > 4'd9) ? 4'd9 : n - 4'd1;
            c = 1'b0;
          end
        end else begin
          if (n >= 4'd9) begin
            n = 4'd0;
          end else begin
            n = n + 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = n;
    end
    return {c, r};
  endfunction

  assign w_sel      = per_en && (per_addr[13:2] == BASE_ADDR[14:3]);
  assign w_wr       = w_sel && (per_we != 2'b00);
  assign w_rd       = w_sel && (per_we == 2'b00);
  assign w_idx      = per_addr[1:0];
  assign w_wr_disp  = w_wr && (w_idx == c_idx_disp);
  assign w_wr_ctrl  = w_wr && (w_idx == c_idx_ctrl);
  assign w_wr_presc = w_wr && (w_idx == c_idx_presc);
  assign w_wr_stat  = w_wr && (w_idx == c_idx_stat);

  assign w_prediv_full = &prediv_q;
  assign w_tick        = ctrl_q[0] && w_prediv_full && (pcnt_q == presc_q);

  always_comb begin
    prediv_d = prediv_q + c_prediv_one;
    pcnt_d   = pcnt_q;
    if (w_prediv_full) begin
      pcnt_d = w_tick ? 16'h0000 : pcnt_q + 16'd1;
    end
    // Reprogramming restarts the period so the first tick is a full period away
    if (!ctrl_q[0] || w_wr_ctrl || w_wr_presc) begin
      prediv_d = '0;
      pcnt_d   = 16'h0000;
    end
  end

  always_comb begin
    w_step_val = disp_q;
    w_step_ovf = 1'b0;
    if (ctrl_q[1]) begin
      {w_step_ovf, w_step_val} = bcd_step(disp_q, ctrl_q[2]);
    end else if (ctrl_q[2]) begin
      w_step_val = disp_q - 16'd1;
      w_step_ovf = (disp_q == 16'h0000);
    end else begin
      w_step_val = disp_q + 16'd1;
      w_step_ovf = (disp_q == 16'hFFFF);
    end
  end

  always_comb begin
    disp_d  = disp_q;
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    ovf_d   = ovf_q;
    irq_d   = ovf_q & ctrl_q[5];

    // A CPU write to DISP swallows a coincident tick entirely
    if (w_wr_disp) begin
      if (per_we[0]) disp_d[7:0]  = per_din[7:0];
      if (per_we[1]) disp_d[15:8] = per_din[15:8];
    end else if (w_tick) begin
      disp_d = w_step_val;
    end

    if (w_wr_ctrl && per_we[0]) begin
      ctrl_d = per_din[5:0] & c_ctrl_mask;
    end

    if (w_wr_presc) begin
      if (per_we[0]) presc_d[7:0]  = per_din[7:0];
      if (per_we[1]) presc_d[15:8] = per_din[15:8];
    end

    if (w_wr_stat && per_we[0] && per_din[0]) begin
      ovf_d = 1'b0;
    end
    if (w_tick && !w_wr_disp && w_step_ovf) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      disp_q   <= 16'h0000;
      ctrl_q   <= 6'h00;
      presc_q  <= 16'h0000;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      prediv_q <= '0;
      pcnt_q   <= 16'h0000;
    end else begin
      disp_q   <= disp_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      prediv_q <= prediv_d;
      pcnt_q   <= pcnt_d;
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (w_rd) begin
      case (w_idx)
        c_idx_disp:  per_dout = disp_q;
        c_idx_ctrl:  per_dout = {10'h000, ctrl_q};
        c_idx_presc: per_dout = presc_q;
        c_idx_stat:  per_dout = {15'h0000, ovf_q};
        default:     per_dout = 16'h0000;
      endcase
    end
  end

  assign s0_src = disp_q[15:12];
  assign s1_src = disp_q[11:8];
  assign s2_src = disp_q[7:4];
  assign s3_src = disp_q[3:0];
  assign irq    = irq_q;

endmodule
`default_nettype wire
